// File: rtl/flood_pkg.sv
// Shared parameters, FSM state encoding and cell layout for the flood-fill engine.
package flood_pkg;
  localparam int MAX_SIZE = 26;
  localparam int COLOR_W  = 3;
  localparam int MOVE_W   = 8;
  localparam int COORD_W  = 5;
  localparam int COUNT_W  = 10;

  localparam logic [COORD_W-1:0] EDGE_LIMIT = COORD_W'(MAX_SIZE);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECOLOR = 2'd1,
    SWEEP   = 2'd2,
    FINISH  = 2'd3
  } flood_state_e;

  typedef struct packed {
    logic               flooded;
    logic [COLOR_W-1:0] color;
  } cell_t;
endpackage

// File: rtl/board_scan_counter.sv
// Raster (x fastest) cell counter over the active board; wraps to (0,0) after the last cell.
module board_scan_counter
  import flood_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               advance,
  input  logic [COORD_W-1:0] size,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               last
);
  logic [COORD_W-1:0] edge_idx;

  assign edge_idx = size - COORD_W'(1);
  assign last     = (x == edge_idx) && (y == edge_idx);

  always_ff @(posedge clk) begin
    if (!rst_n || start) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      if (x == edge_idx) begin
        x <= '0;
        y <= (y == edge_idx) ? '0 : y + COORD_W'(1);
      end else begin
        x <= x + COORD_W'(1);
      end
    end
  end
endmodule

// File: rtl/flood_fill_engine.sv
// Flood-it board engine: owns the cell array, answers colour requests by recolouring the
// flooded region and repeatedly sweeping the board to grow it from cell (0,0).
module flood_fill_engine
  import flood_pkg::*;
(
  input  logic               CLOCK,
  input  logic               RESET_N,
  input  logic [COORD_W-1:0] SIZE,
  input  logic               LOAD_VALID,
  input  logic [COORD_W-1:0] LOAD_X,
  input  logic [COORD_W-1:0] LOAD_Y,
  input  logic [COLOR_W-1:0] LOAD_COLOR,
  input  logic               LOAD_DONE,
  input  logic               COLOR_SEL_SIG,
  input  logic [COLOR_W-1:0] COLOR_SELECTED,
  output logic               CHANGING_COLOR,
  input  logic [COORD_W-1:0] RD_X,
  input  logic [COORD_W-1:0] RD_Y,
  output logic [COLOR_W-1:0] RD_COLOR,
  output logic [MOVE_W-1:0]  MOVES,
  output logic [COUNT_W-1:0] FLOODED_COUNT,
  output logic               WON,
  output flood_state_e       DBG_STATE
);
  // Handshake: a request is the rising edge of COLOR_SEL_SIG seen in IDLE with no win;
  // CHANGING_COLOR rises the next cycle and stays high until the fill is done. The
  // requester keeps COLOR_SEL_SIG and COLOR_SELECTED stable until CHANGING_COLOR falls.
  flood_state_e       state, state_nxt;
  cell_t              board [MAX_SIZE][MAX_SIZE];
  cell_t              cur;
  logic [COORD_W-1:0] size_q, edge_idx, scan_x, scan_y;
  logic [COLOR_W-1:0] target_q;
  logic [COUNT_W-1:0] area;
  logic               sel_q, sel_rise, pass_changed, scan_last;
  logic               scan_start, scan_adv, accept_load, accept_move;
  logic               load_wr, recolor_wr, grow;
  logic               nb_left, nb_right, nb_up, nb_down;

  board_scan_counter u_scan (
    .clk     (CLOCK),
    .rst_n   (RESET_N),
    .start   (scan_start),
    .advance (scan_adv),
    .size    (size_q),
    .x       (scan_x),
    .y       (scan_y),
    .last    (scan_last)
  );

  assign edge_idx   = size_q - COORD_W'(1);
  assign area       = COUNT_W'(size_q) * COUNT_W'(size_q);
  assign sel_rise   = COLOR_SEL_SIG & ~sel_q;
  assign scan_start = (state == IDLE) || (state == FINISH);
  assign scan_adv   = (state == RECOLOR) || (state == SWEEP);
  assign cur        = board[scan_y][scan_x];

  assign nb_left  = (scan_x != '0)       ? board[scan_y][scan_x - COORD_W'(1)].flooded : 1'b0;
  assign nb_right = (scan_x != edge_idx) ? board[scan_y][scan_x + COORD_W'(1)].flooded : 1'b0;
  assign nb_up    = (scan_y != '0)       ? board[scan_y - COORD_W'(1)][scan_x].flooded : 1'b0;
  assign nb_down  = (scan_y != edge_idx) ? board[scan_y + COORD_W'(1)][scan_x].flooded : 1'b0;

  assign grow       = (state == SWEEP) && !cur.flooded && (cur.color == target_q) &&
                      (nb_left || nb_right || nb_up || nb_down);
  assign load_wr    = (state == IDLE) && LOAD_VALID;
  assign recolor_wr = (state == RECOLOR) && cur.flooded;

  assign CHANGING_COLOR = (state != IDLE);
  assign DBG_STATE      = state;
  assign RD_COLOR       = (RD_X < EDGE_LIMIT && RD_Y < EDGE_LIMIT) ? board[RD_Y][RD_X].color : '0;

  always_comb begin
    state_nxt   = state;
    accept_load = 1'b0;
    accept_move = 1'b0;
    case (state)
      IDLE: begin
        if (LOAD_DONE) begin
          state_nxt   = SWEEP;
          accept_load = 1'b1;
        end else if (sel_rise && !WON) begin
          if (COLOR_SELECTED == target_q) begin
            state_nxt = FINISH;
          end else begin
            state_nxt   = RECOLOR;
            accept_move = 1'b1;
          end
        end
      end
      RECOLOR: if (scan_last) state_nxt = SWEEP;
      SWEEP:   if (scan_last) state_nxt = (pass_changed || grow) ? SWEEP : FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      state         <= IDLE;
      size_q        <= COORD_W'(2);
      target_q      <= '0;
      sel_q         <= 1'b0;
      pass_changed  <= 1'b0;
      MOVES         <= '0;
      FLOODED_COUNT <= '0;
      WON           <= 1'b0;
    end else begin
      state <= state_nxt;
      sel_q <= COLOR_SEL_SIG;
      if (accept_load) begin
        size_q        <= SIZE;
        target_q      <= board[0][0].color;
        MOVES         <= '0;
        WON           <= 1'b0;
        FLOODED_COUNT <= COUNT_W'(1);
      end
      if (accept_move) begin
        target_q <= COLOR_SELECTED;
        if (MOVES != '1) MOVES <= MOVES + MOVE_W'(1);
      end
      // Cleared at every pass boundary so each pass decides on its own growth.
      if (state == SWEEP) pass_changed <= scan_last ? 1'b0 : (pass_changed || grow);
      else                pass_changed <= 1'b0;
      if (grow) FLOODED_COUNT <= FLOODED_COUNT + COUNT_W'(1);
      if (state == FINISH) WON <= (FLOODED_COUNT == area);
    end
  end

  for (genvar gy = 0; gy < MAX_SIZE; gy++) begin : g_row
    for (genvar gx = 0; gx < MAX_SIZE; gx++) begin : g_col
      cell_t cell_q;
      logic  hit_scan, hit_load;

      assign hit_scan = (scan_y == COORD_W'(gy)) && (scan_x == COORD_W'(gx));
      assign hit_load = (LOAD_Y == COORD_W'(gy)) && (LOAD_X == COORD_W'(gx));
      assign board[gy][gx] = cell_q;

      always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
          cell_q <= '0;
        end else begin
          if (load_wr && hit_load)    cell_q.color <= LOAD_COLOR;
          if (recolor_wr && hit_scan) cell_q.color <= target_q;
          if (accept_load)            cell_q.flooded <= (gx == 0 && gy == 0);
          else if (grow && hit_scan)  cell_q.flooded <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_flood_fill_engine.sv
// Directed bench for flood_fill_engine: expected values queued at stimulus time, popped at check time.
module tb_flood_fill_engine;
  import flood_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [4:0]   size = 5'd2;
  logic         load_valid = 1'b0;
  logic [4:0]   load_x = '0, load_y = '0;
  logic [2:0]   load_color = '0;
  logic         load_done = 1'b0;
  logic         sel_sig = 1'b0;
  logic [2:0]   sel_color = '0;
  logic         changing;
  logic [4:0]   rd_x = '0, rd_y = '0;
  logic [2:0]   rd_color;
  logic [7:0]   moves;
  logic [9:0]   flooded;
  logic         won;
  flood_state_e dbg_state;

  logic [15:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc;

  always #5 clk = ~clk;

  flood_fill_engine dut (
    .CLOCK          (clk),
    .RESET_N        (rst_n),
    .SIZE           (size),
    .LOAD_VALID     (load_valid),
    .LOAD_X         (load_x),
    .LOAD_Y         (load_y),
    .LOAD_COLOR     (load_color),
    .LOAD_DONE      (load_done),
    .COLOR_SEL_SIG  (sel_sig),
    .COLOR_SELECTED (sel_color),
    .CHANGING_COLOR (changing),
    .RD_X           (rd_x),
    .RD_Y           (rd_y),
    .RD_COLOR       (rd_color),
    .MOVES          (moves),
    .FLOODED_COUNT  (flooded),
    .WON            (won),
    .DBG_STATE      (dbg_state)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_v(input logic [15:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [15:0] obs);
    logic [15:0] exp;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $error("FAIL %s: observed %0d, no expected value queued", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        n_bad++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
    end
  endtask

  function automatic logic [2:0] pat_color(input int pat, input int x, input int y);
    case (pat)
      0: return 3'd1;
      1: return (y == 0) ? 3'd2 : 3'd3;
      2: return 3'((x + y) % 2);
      default: return ((y % 2) == 0 || (y == 1 && x == 4) || (y == 3 && x == 0)) ? 3'd4 : 3'd0;
    endcase
  endfunction

  task automatic load_board(input int pat, input int sz);
    for (int y = 0; y < sz; y++) begin
      for (int x = 0; x < sz; x++) begin
        load_valid = 1'b1;
        load_x     = 5'(x);
        load_y     = 5'(y);
        load_color = pat_color(pat, x, y);
        tick(1);
      end
    end
    load_valid = 1'b0;
  endtask

  task automatic pulse_done(input int sz);
    size      = 5'(sz);
    load_done = 1'b1;
    tick(1);
    load_done = 1'b0;
  endtask

  task automatic request(input logic [2:0] c);
    sel_color = c;
    sel_sig   = 1'b1;
    tick(1);
  endtask

  task automatic release_req();
    sel_sig = 1'b0;
    tick(1);
  endtask

  // Counts cycles with CHANGING_COLOR high, bounded so a stuck DUT still reaches the summary.
  task automatic wait_done(output int n);
    n = 0;
    while (changing === 1'b1 && n < 3000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic read_cell(input int x, input int y, output logic [2:0] c);
    rd_x = 5'(x);
    rd_y = 5'(y);
    #1;
    c = rd_color;
  endtask

  initial begin
    logic [2:0] c;
    logic [2:0] acc;

    // Reset
    tick(3);
    rst_n = 1'b1;
    tick(1);
    expect_v(0); expect_v(0); expect_v(0); expect_v(0); expect_v(0);
    check("rst_changing", {15'b0, changing});
    check("rst_moves", {8'b0, moves});
    check("rst_count", {6'b0, flooded});
    check("rst_won", {15'b0, won});
    read_cell(0, 0, c);
    check("rst_rd00", {13'b0, c});

    // 3x3 uniform: single growing pass plus a confirming pass
    load_board(0, 3);
    expect_v(19); expect_v(9); expect_v(1); expect_v(0);
    pulse_done(3);
    wait_done(cyc);
    check("t1_busy", 16'(cyc));
    check("t1_count", {6'b0, flooded});
    check("t1_won", {15'b0, won});
    check("t1_moves", {8'b0, moves});

    // 4x4 row0 colour 2, rest 3
    load_board(1, 4);
    expect_v(33); expect_v(4); expect_v(0);
    pulse_done(4);
    wait_done(cyc);
    check("t2_init_busy", 16'(cyc));
    check("t2_init_count", {6'b0, flooded});
    check("t2_init_won", {15'b0, won});
    expect_v(49); expect_v(1); expect_v(16); expect_v(1); expect_v(3); expect_v(3);
    request(3'd3);
    wait_done(cyc);
    check("t2_busy", 16'(cyc));
    check("t2_moves", {8'b0, moves});
    check("t2_count", {6'b0, flooded});
    check("t2_won", {15'b0, won});
    read_cell(3, 0, c);
    check("t2_rd30", {13'b0, c});
    read_cell(2, 3, c);
    check("t2_rd23", {13'b0, c});
    tick(1);
    release_req();
    // Requests after a win are ignored
    expect_v(0); expect_v(1);
    request(3'd5);
    check("t2_won_ignore", {15'b0, changing});
    check("t2_won_moves", {8'b0, moves});
    release_req();

    // 4x4 checkerboard: same-colour request, held request, second move
    load_board(2, 4);
    expect_v(17); expect_v(1);
    pulse_done(4);
    wait_done(cyc);
    check("t3_init_busy", 16'(cyc));
    check("t3_init_count", {6'b0, flooded});
    expect_v(1); expect_v(0);
    request(3'd0);
    wait_done(cyc);
    check("t3_same_busy", 16'(cyc));
    check("t3_same_moves", {8'b0, moves});
    release_req();
    expect_v(49); expect_v(1); expect_v(3);
    request(3'd1);
    wait_done(cyc);
    check("t3_move1_busy", 16'(cyc));
    check("t3_move1_moves", {8'b0, moves});
    check("t3_move1_count", {6'b0, flooded});
    expect_v(0); expect_v(1);
    tick(4);
    check("t3_held_idle", {15'b0, changing});
    check("t3_held_moves", {8'b0, moves});
    release_req();
    expect_v(49); expect_v(2); expect_v(6); expect_v(0);
    request(3'd0);
    wait_done(cyc);
    check("t3_move2_busy", 16'(cyc));
    check("t3_move2_moves", {8'b0, moves});
    check("t3_move2_count", {6'b0, flooded});
    check("t3_move2_won", {15'b0, won});
    release_req();

    // 5x5 serpentine of colour 4: six sweep passes
    load_board(3, 5);
    expect_v(151); expect_v(17); expect_v(0); expect_v(0); expect_v(4); expect_v(0);
    pulse_done(5);
    wait_done(cyc);
    check("t5_busy", 16'(cyc));
    check("t5_count", {6'b0, flooded});
    check("t5_won", {15'b0, won});
    check("t5_moves", {8'b0, moves});
    read_cell(4, 1, c);
    check("t5_rd41", {13'b0, c});
    read_cell(1, 1, c);
    check("t5_rd11", {13'b0, c});
    tick(1);

    // Reset in the middle of a sweep
    expect_v(1);
    request(3'd0);
    tick(40);
    check("t6_pre_moves", {8'b0, moves});
    expect_v(0); expect_v(0); expect_v(0); expect_v(0); expect_v(16'(IDLE)); expect_v(0);
    rst_n   = 1'b0;
    sel_sig = 1'b0;
    tick(1);
    check("t6_changing", {15'b0, changing});
    check("t6_moves", {8'b0, moves});
    check("t6_count", {6'b0, flooded});
    check("t6_won", {15'b0, won});
    check("t6_state", {14'b0, dbg_state});
    acc = '0;
    for (int y = 0; y < 26; y++) begin
      for (int x = 0; x < 26; x++) begin
        read_cell(x, y, c);
        acc = acc | c;
      end
    end
    check("t6_rd_all", {13'b0, acc});
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
